bus_wait_ctrl: RTL and testbench
================================

// Module: bus_wait_ctrl
// PURPOSE
//  Wait-state sequencer between the address decoder's active-low chip selects and the
//  W65C02 RDY input. Per target it stretches the CPU bus cycle by a fixed wait count.
//  It emits a one-cycle data-valid strobe tagged with the device code.
//  It enforces a minimum recovery gap between consecutive UART accesses.
// PARAMETERS
//  RAM_WAIT       0   wait cycles for RAM accesses
//  SID_WAIT       3   wait cycles for SID accesses
//  VIA_WAIT       2   wait cycles for VIA1/VIA2 accesses
//  UART_WAIT      2   wait cycles for UART accesses
//  BIFROST_WAIT   0   wait cycles for bifrost register accesses
//  UART_RECOVERY  4   minimum idle cycles after a UART strobe before the next UART access
//  CW             4   counter width; every wait/recovery parameter must be <= 2**CW-1
// PORTS
//  clock        in   1   system clock; all state changes on its rising edge
//  reset_n      in   1   synchronous active-low reset
//  cycle_start  in   1   one-cycle pulse marking the start of a CPU bus cycle
//  rw           in   1   CPU R/W (1=read), sampled with cycle_start
//  ram_cs       in   1   active-low select from the decoder
//  sid_cs       in   1   active-low select from the decoder
//  via1_cs      in   1   active-low select from the decoder
//  via2_cs      in   1   active-low select from the decoder
//  uart_cs      in   1   active-low select from the decoder
//  bifrost_cs   in   1   active-low select from the decoder
//  rdy          out  1   to CPU RDY; 0 stalls the current cycle
//  strobe       out  1   one-cycle pulse: target access completes this cycle
//  strobe_rw    out  1   rw latched at cycle_start, valid with strobe
//  dev          out  3   device code latched at cycle_start: 0 none,1 ram,2 sid,3 via1,4 via2,5 uart,6 bifrost
//  busy         out  1   1 in any state other than IDLE
//  err          out  1   sticky: cycle_start seen while busy, or >1 select asserted
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE, rdy=1, strobe=0, strobe_rw=0, dev=0, busy=0,
//    err=0, wait and recovery counters=0. Reset mid-cycle aborts the access; no strobe is issued.
//  - Outputs are registered. States: IDLE, HOLD, WAIT, DONE.
//  - IDLE + cycle_start: latch rw and dev from the selects, then load wcnt with the device's wait.
//    Select priority when several are low: bifrost>uart>via1>via2>sid>ram, and set err.
//    With no select low, dev=0 and wait=0.
//  - Transitions out of IDLE on cycle_start:
//    - uart target with rcnt>0 -> HOLD.
//    - otherwise wcnt>0 -> WAIT.
//    - otherwise -> DONE.
//  - HOLD: rdy=0; leave when rcnt reaches 0 -> WAIT (UART_WAIT>0) or DONE.
//  - WAIT: rdy=0, wcnt decrements each cycle; at wcnt==1 -> DONE.
//  - DONE: rdy=1 and strobe=1 for exactly one cycle, then -> IDLE.
//    A uart DONE loads rcnt=UART_RECOVERY.
//  - Latency: cycle_start at edge T, wait N, no hold: rdy=0 during cycles T+1..T+N;
//    rdy=1 with strobe at T+N+1. N=0 gives strobe at T+1 and rdy never drops.
//  - rcnt decrements every cycle while nonzero, in every state; it saturates at 0.
//    Non-UART accesses ignore rcnt.
//  - cycle_start while busy=1 is ignored apart from setting err; the current sequence is unaffected.
//  - cycle_start in the same cycle as DONE counts as busy and sets err.
//    cycle_start in the cycle after DONE is accepted normally.
//  - err clears only on reset.
// TESTING
//  1. Reset, then RAM read (ram_cs=0, rw=1):
//     strobe at T+1 with dev=1, strobe_rw=1; rdy stays 1; busy=1 only at T+1.
//  2. SID write, SID_WAIT=3:
//     rdy=0 at T+1..T+3; strobe with dev=2, strobe_rw=0 at T+4; rdy=1 from T+4.
//  3. Two UART reads with cycle_start 1 cycle after the first strobe (UART_RECOVERY=4):
//     second access first HOLDs for the remaining rcnt, then waits 2 cycles.
//     rdy stays 0 until the second strobe.
//  4. UART read, then VIA1 read immediately after:
//     the VIA1 read is not held; strobe at T+3 (VIA_WAIT=2) with dev=3.
//  5. uart_cs=0 and via2_cs=0 together at cycle_start: dev=5, err=1.
//     A cycle_start pulse during WAIT is ignored; err stays 1.
//  6. reset_n=0 during a SID WAIT:
//     next cycle rdy=1, busy=0, no strobe.
//     A RAM access afterwards completes at T+1.

Source files
------------

// File: rtl/bus_wait_ctrl.sv
//------------------------------------------------------------------------------
// Module      : bus_wait_ctrl
// Description : Wait-state sequencer between the decoder chip selects and the
//               W65C02 RDY input. Stretches each bus cycle by a per-target
//               wait count, emits a tagged completion strobe and enforces a
//               recovery gap between consecutive UART accesses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bus_wait_ctrl #(
    parameter int unsigned RAM_WAIT      = 0,
    parameter int unsigned SID_WAIT      = 3,
    parameter int unsigned VIA_WAIT      = 2,
    parameter int unsigned UART_WAIT     = 2,
    parameter int unsigned BIFROST_WAIT  = 0,
    parameter int unsigned UART_RECOVERY = 4,
    parameter int unsigned CW            = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cycle_start,
    input  logic       rw,
    input  logic       ram_cs,
    input  logic       sid_cs,
    input  logic       via1_cs,
    input  logic       via2_cs,
    input  logic       uart_cs,
    input  logic       bifrost_cs,
    output logic       rdy,
    output logic       strobe,
    output logic       strobe_rw,
    output logic [2:0] dev,
    output logic       busy,
    output logic       err
);

    // Device codes carried on dev
    localparam logic [2:0] c_dev_none    = 3'd0;
    localparam logic [2:0] c_dev_ram     = 3'd1;
    localparam logic [2:0] c_dev_sid     = 3'd2;
    localparam logic [2:0] c_dev_via1    = 3'd3;
    localparam logic [2:0] c_dev_via2    = 3'd4;
    localparam logic [2:0] c_dev_uart    = 3'd5;
    localparam logic [2:0] c_dev_bifrost = 3'd6;

    localparam logic [CW-1:0] c_zero         = '0;
    localparam logic [CW-1:0] c_one          = CW'(1);
    localparam logic [CW-1:0] c_ram_wait     = CW'(RAM_WAIT);
    localparam logic [CW-1:0] c_sid_wait     = CW'(SID_WAIT);
    localparam logic [CW-1:0] c_via_wait     = CW'(VIA_WAIT);
    localparam logic [CW-1:0] c_uart_wait    = CW'(UART_WAIT);
    localparam logic [CW-1:0] c_bifrost_wait = CW'(BIFROST_WAIT);
    localparam logic [CW-1:0] c_uart_rec     = CW'(UART_RECOVERY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [2:0]      dev_q, dev_d;
    logic            rw_q, rw_d;
    logic            err_q, err_d;
    logic            rdy_q, strobe_q, busy_q;

    // Active-high view of the selects, ordered by priority (bit 5 highest)
    logic [5:0]      w_sel;
    logic            w_multi;
    logic [2:0]      w_dev;
    logic [CW-1:0]   w_wait;

    assign w_sel   = ~{bifrost_cs, uart_cs, via1_cs, via2_cs, sid_cs, ram_cs};
    // More than one bit set: clearing the lowest set bit leaves something behind
    assign w_multi = (w_sel & (w_sel - 6'd1)) != 6'd0;

    // Priority-decode the selects into a device code and its wait count
    always_comb begin
        w_dev  = c_dev_none;
        w_wait = c_zero;
        if (w_sel[5]) begin
            w_dev  = c_dev_bifrost;
            w_wait = c_bifrost_wait;
        end else if (w_sel[4]) begin
            w_dev  = c_dev_uart;
            w_wait = c_uart_wait;
        end else if (w_sel[3]) begin
            w_dev  = c_dev_via1;
            w_wait = c_via_wait;
        end else if (w_sel[2]) begin
            w_dev  = c_dev_via2;
            w_wait = c_via_wait;
        end else if (w_sel[1]) begin
            w_dev  = c_dev_sid;
            w_wait = c_sid_wait;
        end else if (w_sel[0]) begin
            w_dev  = c_dev_ram;
            w_wait = c_ram_wait;
        end
    end

    // Next-state logic for the sequencer, counters and latched access info
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        // Recovery counter runs down in every state and parks at zero
        rcnt_d  = (rcnt_q != c_zero) ? rcnt_q - c_one : c_zero;
        dev_d   = dev_q;
        rw_d    = rw_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cycle_start) begin
                    dev_d  = w_dev;
                    rw_d   = rw;
                    wcnt_d = w_wait;
                    if (w_multi) begin
                        err_d = 1'b1;
                    end
                    if ((w_dev == c_dev_uart) && (rcnt_q != c_zero)) begin
                        state_d = S_HOLD;
                    end else if (w_wait != c_zero) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_HOLD: begin
                // Leave on the edge where the recovery counter reaches zero
                if (rcnt_q <= c_one) begin
                    state_d = (wcnt_q != c_zero) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - c_one;
                if (wcnt_q <= c_one) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (dev_q == c_dev_uart) begin
                    rcnt_d = c_uart_rec;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new cycle arriving while a sequence is in flight (DONE included)
        // is dropped but flagged
        if (cycle_start && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    // State and output registers; outputs are decoded from the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= c_zero;
            rcnt_q   <= c_zero;
            dev_q    <= c_dev_none;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b1;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            dev_q    <= dev_d;
            rw_q     <= rw_d;
            err_q    <= err_d;
            rdy_q    <= !((state_d == S_HOLD) || (state_d == S_WAIT));
            strobe_q <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign rdy       = rdy_q;
    assign strobe    = strobe_q;
    assign strobe_rw = rw_q;
    assign dev       = dev_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_wait_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_bus_wait_ctrl
// Description : Self-checking bench for bus_wait_ctrl. A timeline model
//               predicts, per accepted access, the stall window, strobe cycle
//               and latched tags; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bus_wait_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, cycle_start, rw;
    logic [5:0] cs;   // active low: {bifrost, uart, via1, via2, sid, ram}
    logic       rdy, strobe, strobe_rw, busy, err;
    logic [2:0] dev;

    int vecs  = 0;
    int fails = 0;

    bus_wait_ctrl dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .cycle_start (cycle_start),
        .rw          (rw),
        .ram_cs      (cs[0]),
        .sid_cs      (cs[1]),
        .via2_cs     (cs[2]),
        .via1_cs     (cs[3]),
        .uart_cs     (cs[4]),
        .bifrost_cs  (cs[5]),
        .rdy         (rdy),
        .strobe      (strobe),
        .strobe_rw   (strobe_rw),
        .dev         (dev),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted access is a window on a cycle timeline
    int code_of[6] = '{1, 2, 4, 3, 5, 6};     // cs bit index -> device code
    int waits[7]   = '{0, 0, 3, 2, 2, 2, 0};  // device code -> wait cycles
    int rec_gap    = 4;

    int   cyc       = 0;
    int   acc_at    = -100;
    int   strobe_at = -100;
    int   st_from   = 1;
    int   st_to     = 0;
    int   last_uart = -1000;
    logic [2:0] m_dev = 3'd0;
    logic m_rw  = 1'b0;
    logic m_err = 1'b0;
    logic exp_rdy, exp_strobe, exp_busy, exp_rw, exp_err;
    logic [2:0] exp_dev;

    // Advance the model by the current cycle's inputs, then clock the DUT
    task automatic tick();
        int r, h, n, code;
        logic [5:0] sel;
        if (!reset_n) begin
            acc_at = -100; strobe_at = -100; st_from = 1; st_to = 0;
            last_uart = -1000; m_dev = 3'd0; m_rw = 1'b0; m_err = 1'b0;
        end else begin
            if (cyc == strobe_at && m_dev == 3'd5) last_uart = cyc;
            if (cycle_start) begin
                if (cyc > acc_at && cyc <= strobe_at) begin
                    m_err = 1'b1;
                end else begin
                    sel = ~cs;
                    if ($countones(sel) > 1) m_err = 1'b1;
                    code = 0;
                    for (int i = 5; i >= 0; i--)
                        if (sel[i] && code == 0) code = code_of[i];
                    n = waits[code];
                    r = rec_gap - (cyc - last_uart - 1);
                    if (r < 0) r = 0;
                    h = (code == 5 && r > 0) ? ((r > 1) ? r - 1 : 1) : 0;
                    acc_at    = cyc;
                    st_from   = cyc + 1;
                    st_to     = cyc + h + n;
                    strobe_at = cyc + h + n + 1;
                    m_dev     = 3'(code);
                    m_rw      = rw;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_rdy    = !(cyc >= st_from && cyc <= st_to);
        exp_strobe = (cyc == strobe_at);
        exp_busy   = (cyc > acc_at && cyc <= strobe_at);
        exp_dev    = m_dev;
        exp_rw     = m_rw;
        exp_err    = m_err;
        cycle_start = 1'b0;
        cs          = '1;
        reset_n     = 1'b1;
        rw          = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        vecs++;
        if ({rdy, strobe, strobe_rw, busy, err, dev} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset: got rdy%b stb%b rw%b busy%b err%b dev%0d, want 1 0 0 0 0 dev0",
                     rdy, strobe, strobe_rw, busy, err, dev);
        end
    endtask

    task automatic test_ram_read();
        int t0, sc = -1, low = 0, bz = 0;
        cycle_start = 1'b1; rw = 1'b1; cs = 6'b111110; t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL ram cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (i > 0 && rdy !== 1'b1) low++;
            if (i > 0 && busy === 1'b1) bz++;
            if (strobe === 1'b1 && sc < 0) sc = cyc - t0;
            tick();
        end
        vecs++;
        if (sc != 1 || low != 0 || bz != 1) begin
            fails++;
            $display("FAIL ram_timing: strobe at T+%0d rdy-low %0d busy %0d, want T+1 0 1", sc, low, bz);
        end
    endtask

    task automatic test_sid_write();
        int t0, sc = -1, low = 0;
        cycle_start = 1'b1; rw = 1'b0; cs = 6'b111101; t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL sid cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (rdy === 1'b0) low++;
            if (strobe === 1'b1 && sc < 0) begin
                sc = cyc - t0;
                if (dev !== 3'd2 || strobe_rw !== 1'b0) begin
                    fails++;
                    $display("FAIL sid_tag: dev %0d rw %b, want 2 0", dev, strobe_rw);
                end
            end
            tick();
        end
        vecs++;
        if (sc != 4 || low != 3) begin
            fails++;
            $display("FAIL sid_timing: strobe at T+%0d rdy-low %0d, want T+4 3", sc, low);
        end
    endtask

    task automatic test_uart_recovery();
        int d = -1, t2 = -1, s2 = -1, low = 0;
        cycle_start = 1'b1; rw = 1'b1; cs = 6'b101111;
        for (int i = 0; i < 16; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL uart_rec cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (t2 >= 0 && cyc > t2 && s2 < 0) begin
                if (strobe === 1'b1) s2 = cyc - t2;
                else if (rdy === 1'b0) low++;
            end
            if (strobe === 1'b1 && d < 0) d = cyc;
            if (d >= 0 && cyc == d + 1) begin
                cycle_start = 1'b1; rw = 1'b1; cs = 6'b101111; t2 = cyc;
            end
            tick();
        end
        vecs++;
        if (s2 != 6 || low != 5) begin
            fails++;
            $display("FAIL uart_rec_timing: 2nd strobe at T+%0d rdy-low %0d, want T+6 5", s2, low);
        end
    endtask

    task automatic test_uart_then_via();
        int d = -1, tv = -1, sv = -1;
        logic [2:0] dv = 3'd0;
        cycle_start = 1'b1; rw = 1'b1; cs = 6'b101111;
        for (int i = 0; i < 12; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL uart_via cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (tv >= 0 && cyc > tv && sv < 0 && strobe === 1'b1) begin
                sv = cyc - tv; dv = dev;
            end
            if (strobe === 1'b1 && d < 0) d = cyc;
            if (d >= 0 && cyc == d + 1) begin
                cycle_start = 1'b1; rw = 1'b1; cs = 6'b110111; tv = cyc;
            end
            tick();
        end
        vecs++;
        if (sv != 3 || dv !== 3'd3) begin
            fails++;
            $display("FAIL via_after_uart: strobe at T+%0d dev %0d, want T+3 dev 3", sv, dv);
        end
    endtask

    task automatic test_multi_select_err();
        int t0, sc = -1;
        cycle_start = 1'b1; rw = 1'b1; cs = 6'b101011; t0 = cyc;
        for (int i = 0; i < 7; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL multi cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (strobe === 1'b1 && sc < 0) sc = cyc - t0;
            if (cyc == t0 + 1) begin
                cycle_start = 1'b1; cs = 6'b111110;
            end
            tick();
        end
        vecs++;
        if (sc != 3 || err !== 1'b1 || dev !== 3'd5) begin
            fails++;
            $display("FAIL multi_result: strobe at T+%0d err %b dev %0d, want T+3 1 5", sc, err, dev);
        end
    endtask

    task automatic test_reset_mid_wait();
        int t0, sc = -1, stb = 0;
        cycle_start = 1'b1; rw = 1'b0; cs = 6'b111101; t0 = cyc;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        vecs++;
        if (rdy !== 1'b1 || busy !== 1'b0 || strobe !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got rdy%b busy%b stb%b err%b, want 1 0 0 0", rdy, busy, strobe, err);
        end
        for (int i = 0; i < 4; i++) begin
            if (strobe === 1'b1) stb++;
            tick();
        end
        cycle_start = 1'b1; rw = 1'b1; cs = 6'b111110; t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL reset_mid cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            if (strobe === 1'b1 && sc < 0) sc = cyc - t0;
            tick();
        end
        vecs++;
        if (stb != 0 || sc != 1) begin
            fails++;
            $display("FAIL reset_mid_timing: stray strobes %0d, ram strobe at T+%0d, want 0 and T+1", stb, sc);
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 600; i++) begin
            vecs++;
            if ({rdy, strobe, busy, err, dev} !== {exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev} ||
                (exp_strobe && strobe_rw !== exp_rw)) begin
                fails++;
                $display("FAIL random cyc=%0d got rdy%b stb%b busy%b err%b dev%0d rw%b want %b %b %b %b %0d %b",
                         cyc, rdy, strobe, busy, err, dev, strobe_rw, exp_rdy, exp_strobe, exp_busy, exp_err, exp_dev, exp_rw);
            end
            k = $urandom_range(0, 9);
            if (k < 7)      cs = ~(6'b000001 << $urandom_range(0, 5));
            else if (k < 8) cs = '1;
            else            cs = 6'($urandom);
            cycle_start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 2) reset_n = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0; cycle_start = 1'b0; rw = 1'b0; cs = '1;
        test_reset();
        test_ram_read();
        test_sid_write();
        for (int i = 0; i < 6; i++) tick();
        test_uart_recovery();
        for (int i = 0; i < 6; i++) tick();
        test_uart_then_via();
        for (int i = 0; i < 6; i++) tick();
        test_multi_select_err();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

`default_nettype wire
